// File: rtl/register_file_pkg.sv
// Shared types and RV32 sizing constants for the scoreboarded register file.
package register_file_pkg;

    localparam int RV_DATA_W = 32;
    localparam int RV_ADDR_W = 5;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_wr_decoder.sv
// Address to one-hot decoder with enable; used for the write, reserve and clear paths.
module rf_wr_decoder #(
    parameter int ADDR_W = 5
) (
    input  logic                   en_i,
    input  logic [ADDR_W-1:0]      addr_i,
    output logic [(2**ADDR_W)-1:0] onehot_o
);

    // One-hot select of the addressed entry when enabled
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end else begin
            onehot_o = '0;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with busy scoreboard, optional write bypass
// and a sequenced clear engine that walks every entry once.
module register_file_sb
    import register_file_pkg::*;
#(
    parameter int DATA_W   = RV_DATA_W,
    parameter int ADDR_W   = RV_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_ena,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_ena,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

    rf_state_t          state_q;
    logic [ADDR_W-1:0]  clr_ptr_q;
    logic               clr_busy_q;
    logic               clr_done_q;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [DEPTH-1:0]   busy_q;
    logic [DEPTH-1:0]   busy_d;

    logic               clearing_s;
    logic               wr_en_s;
    logic               rsv_en_s;
    logic [DEPTH-1:0]   wr_oh_s;
    logic [DEPTH-1:0]   rsv_oh_s;
    logic [DEPTH-1:0]   clr_oh_s;

    // The clear engine owns the array, so pipeline writes and reserves are dropped while it runs
    assign clearing_s = (state_q == RF_CLEAR);
    assign wr_en_s    = wr_ena  && !clearing_s && !((ZERO_REG != 0) && (wr_addr  == {ADDR_W{1'b0}}));
    assign rsv_en_s   = rsv_ena && !clearing_s && !((ZERO_REG != 0) && (rsv_addr == {ADDR_W{1'b0}}));

    rf_wr_decoder #(.ADDR_W(ADDR_W)) u_wr_dec  (.en_i(wr_en_s),    .addr_i(wr_addr),   .onehot_o(wr_oh_s));
    rf_wr_decoder #(.ADDR_W(ADDR_W)) u_rsv_dec (.en_i(rsv_en_s),   .addr_i(rsv_addr),  .onehot_o(rsv_oh_s));
    rf_wr_decoder #(.ADDR_W(ADDR_W)) u_clr_dec (.en_i(clearing_s), .addr_i(clr_ptr_q), .onehot_o(clr_oh_s));

    // Next-state of storage and busy; a same-cycle reserve wins over the write's busy clear
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int j = 0; j < DEPTH; j++) begin
            if (clr_oh_s[j]) begin
                mem_d[j]  = '0;
                busy_d[j] = 1'b0;
            end else begin
                mem_d[j]  = wr_oh_s[j] ? wr_data : mem_q[j];
                busy_d[j] = rsv_oh_s[j] ? 1'b1 : (wr_oh_s[j] ? 1'b0 : busy_q[j]);
            end
        end
    end

    // Storage and busy vector registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // Clear sequencer; ends on the last index rather than pointer wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RF_IDLE;
            clr_ptr_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                RF_IDLE: begin
                    clr_done_q <= 1'b0;
                    clr_ptr_q  <= '0;
                    if (clr_req) begin
                        state_q    <= RF_CLEAR;
                        clr_busy_q <= 1'b1;
                    end else begin
                        state_q    <= RF_IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                RF_CLEAR: begin
                    if (clr_ptr_q == LAST_PTR) begin
                        state_q    <= RF_IDLE;
                        clr_ptr_q  <= '0;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        state_q    <= RF_CLEAR;
                        clr_ptr_q  <= clr_ptr_q + ADDR_W'(1);
                        clr_busy_q <= 1'b1;
                        clr_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RF_IDLE;
                    clr_ptr_q  <= '0;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    // Combinational read ports; bypass is held off during reset and while clearing
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              zero_hit_s;
        logic              byp_hit_s;

        assign addr_s     = rd_addr[i*ADDR_W +: ADDR_W];
        assign zero_hit_s = (ZERO_REG != 0) && (addr_s == {ADDR_W{1'b0}});
        assign byp_hit_s  = (BYPASS != 0) && rst && wr_ena && !clearing_s && (wr_addr == addr_s);

        assign rd_data[i*DATA_W +: DATA_W] = zero_hit_s ? {DATA_W{1'b0}} :
                                             (byp_hit_s ? wr_data : mem_q[addr_s]);
        assign rd_busy[i] = !zero_hit_s && !byp_hit_s && busy_q[addr_s];
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: a default RV32 instance (bypass on) and a
// 64-bit, 4-port instance without bypass, both checked against an array model.
module tb_register_file_sb;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_ena;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         rsv_ena;
    logic [4:0]   rsv_addr;
    logic         clr_req;
    logic [9:0]   rda;
    logic [19:0]  rdb;
    logic [63:0]  rd_data_a;
    logic [1:0]   rd_busy_a;
    logic [255:0] rd_data_b;
    logic [3:0]   rd_busy_b;
    logic         clr_busy_a, clr_done_a, clr_busy_b, clr_done_b;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] m_mem  [32];
    logic        m_busy [32];

    always #5 clk = ~clk;

    register_file_sb dut_a (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data[31:0]),
        .rsv_ena(rsv_ena), .rsv_addr(rsv_addr), .rd_addr(rda), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
    );

    register_file_sb #(.DATA_W(64), .NUM_RD(4), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_ena(rsv_ena), .rsv_addr(rsv_addr), .rd_addr(rdb), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 64'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge outside of a clear
    task automatic model_edge();
        if (wr_ena && wr_addr != 5'd0) begin
            m_mem[wr_addr]  = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (rsv_ena && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_ena  = 1'b0;
        rsv_ena = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic check_reads(input string tag);
        logic [4:0]  a;
        logic        hit;
        logic [63:0] ev;
        #1;
        for (int p = 0; p < 2; p++) begin
            a   = rda[p*5 +: 5];
            hit = wr_ena && (wr_addr == a) && (a != 5'd0);
            ev  = (a == 5'd0) ? 64'd0 : (hit ? wr_data : m_mem[a]);
            chk($sformatf("%s_a%0d_data", tag, p), {32'd0, rd_data_a[p*32 +: 32]}, {32'd0, ev[31:0]});
            chk($sformatf("%s_a%0d_busy", tag, p), {63'd0, rd_busy_a[p]},
                {63'd0, (a != 5'd0) && !hit && m_busy[a]});
        end
        for (int p = 0; p < 4; p++) begin
            a = rdb[p*5 +: 5];
            chk($sformatf("%s_b%0d_data", tag, p), rd_data_b[p*64 +: 64], (a == 5'd0) ? 64'd0 : m_mem[a]);
            chk($sformatf("%s_b%0d_busy", tag, p), {63'd0, rd_busy_b[p]}, {63'd0, (a != 5'd0) && m_busy[a]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, busy_cnt_b, done_cnt, done_at, got;

        rst = 1'b0; idle();
        wr_addr = 5'd0; wr_data = 64'd0; rsv_addr = 5'd0;
        rda = {5'd5, 5'd5}; rdb = {4{5'd5}};
        model_reset();
        #2;
        check_reads("reset");
        chk("reset_clr_busy", {62'd0, clr_busy_a, clr_busy_b}, 64'd0);
        chk("reset_clr_done", {62'd0, clr_done_a, clr_done_b}, 64'd0);
        @(negedge clk); rst = 1'b1;

        // write x5, then asynchronous reset wipes it
        wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 64'h0000_0000_DEAD_BEEF;
        tick(); idle();
        check_reads("wr_x5");
        chk("wr_x5_const", {32'd0, rd_data_a[31:0]}, 64'hDEAD_BEEF);
        #2 rst = 1'b0; model_reset();
        check_reads("rst_x5");
        chk("rst_x5_const", {32'd0, rd_data_a[63:32]}, 64'd0);
        @(negedge clk); rst = 1'b1;

        // x0 protection
        wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 64'h1234;
        rsv_ena = 1'b1; rsv_addr = 5'd0; rda = 10'd0; rdb = 20'd0;
        check_reads("x0_same");
        tick(); idle();
        check_reads("x0_after");

        // bypass on A, no bypass on B
        wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 64'h0000_0000_A5A5_0001;
        rda = {5'd7, 5'd0}; rdb = {5'd0, 5'd0, 5'd7, 5'd0};
        check_reads("byp");
        chk("byp_a1_data", {32'd0, rd_data_a[63:32]}, 64'hA5A5_0001);
        chk("byp_a1_busy", {63'd0, rd_busy_a[1]}, 64'd0);
        chk("nobyp_b1_old", rd_data_b[127:64], 64'd0);
        tick(); idle();
        #1 chk("nobyp_b1_new", rd_data_b[127:64], 64'hA5A5_0001);

        // scoreboard
        rsv_ena = 1'b1; rsv_addr = 5'd3; rda = {5'd3, 5'd3}; rdb = {4{5'd3}};
        tick(); idle();
        check_reads("rsv_x3");
        chk("rsv_x3_busy", {63'd0, rd_busy_a[0]}, 64'd1);
        rsv_ena = 1'b1; rsv_addr = 5'd3; wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 64'h99;
        tick(); idle();
        check_reads("rsvwr_x3");
        chk("rsvwr_x3_busy", {63'd0, rd_busy_b[2]}, 64'd1);
        wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 64'h42;
        tick(); idle();
        check_reads("wr_x3");
        chk("wr_x3_busy", {63'd0, rd_busy_a[1]}, 64'd0);
        chk("wr_x3_data", rd_data_b[63:0], 64'h42);

        // randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            wr_ena   = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom);
            wr_data  = {$urandom, $urandom};
            rsv_ena  = 1'($urandom_range(0, 1));
            rsv_addr = 5'($urandom);
            rda      = 10'($urandom);
            rdb      = 20'($urandom);
            if ($urandom_range(0, 2) == 0) rda[9:5] = wr_addr;
            if ($urandom_range(0, 2) == 0) rdb[4:0] = wr_addr;
            check_reads("rnd");
            tick();
        end
        idle();

        // four ports on four distinct entries
        for (int i = 10; i < 14; i++) begin
            wr_ena = 1'b1; wr_addr = 5'(i); wr_data = 64'h0123_4567_89AB_0000 | 64'(i);
            tick();
        end
        idle();
        rdb = {5'd13, 5'd12, 5'd11, 5'd10};
        check_reads("four_ports");
        for (int p = 0; p < 4; p++)
            chk($sformatf("four_ports_const%0d", p), rd_data_b[p*64 +: 64], 64'h0123_4567_89AB_0000 | 64'(p + 10));

        // fill, then full clear with an ignored write to x9
        for (int i = 1; i < 32; i++) begin
            wr_ena = 1'b1; wr_addr = 5'(i); wr_data = {32'hC0DE_0000 | 32'(i), 32'h5A00_0000 | 32'(i)};
            tick();
        end
        idle();
        rsv_ena = 1'b1; rsv_addr = 5'd4; tick(); idle();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        busy_cnt = 0; busy_cnt_b = 0; done_cnt = 0; done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
                rsv_ena = 1'b1; rsv_addr = 5'd9; rda = {5'd9, 5'd9};
            end else if (k == 7) begin
                idle(); clr_req = 1'b1;
            end else if (k == 10) begin
                idle(); rda = {5'd20, 5'd2};
            end else begin
                idle();
            end
            #1;
            if (clr_busy_a) busy_cnt++;
            if (clr_busy_b) busy_cnt_b++;
            if (clr_done_a) begin done_cnt++; done_at = k; end
            if (k == 5) begin
                chk("clr_nobyp_data", {32'd0, rd_data_a[63:32]}, {32'd0, m_mem[9][31:0]});
                chk("clr_nobyp_busy", {63'd0, rd_busy_a[1]}, 64'd0);
            end
            if (k == 10) begin
                chk("clr_mid_x2", {32'd0, rd_data_a[31:0]}, 64'd0);
                chk("clr_mid_x20", {32'd0, rd_data_a[63:32]}, {32'd0, m_mem[20][31:0]});
            end
            @(posedge clk); @(negedge clk);
        end
        idle();
        chk("clr_busy_len_a", 64'(busy_cnt), 64'd32);
        chk("clr_busy_len_b", 64'(busy_cnt_b), 64'd32);
        chk("clr_done_cnt", 64'(done_cnt), 64'd1);
        chk("clr_done_at", 64'(done_at), 64'd33);
        model_reset();
        for (int a = 0; a < 32; a++) begin
            rda = {2{5'(a)}}; rdb = {4{5'(a)}};
            check_reads("clr_zero");
        end

        // reset in clear cycle 10, then a fresh clear starts at entry 0
        wr_ena = 1'b1; wr_addr = 5'd1; wr_data = 64'h11; tick();
        wr_addr = 5'd2; wr_data = 64'h22; tick(); idle();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        #1 rst = 1'b0;
        #1 chk("rst_mid_clr_busy", {62'd0, clr_busy_a, clr_busy_b}, 64'd0);
        model_reset();
        @(negedge clk); rst = 1'b1;
        #1 chk("rst_mid_clr_after", {62'd0, clr_busy_a, clr_done_a}, 64'd0);
        wr_ena = 1'b1; wr_addr = 5'd1; wr_data = 64'h11; tick();
        wr_addr = 5'd2; wr_data = 64'h22; tick();
        wr_addr = 5'd31; wr_data = 64'h31; tick(); idle();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        @(posedge clk); @(negedge clk);
        rda = {5'd2, 5'd1};
        #1 chk("restart_k2_x1", {32'd0, rd_data_a[31:0]}, 64'h11);
        chk("restart_k2_x2", {32'd0, rd_data_a[63:32]}, 64'h22);
        @(posedge clk); @(negedge clk);
        #1 chk("restart_k3_x1", {32'd0, rd_data_a[31:0]}, 64'd0);
        chk("restart_k3_x2", {32'd0, rd_data_a[63:32]}, 64'h22);
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            @(posedge clk); @(negedge clk);
            #1 if (clr_done_a && clr_done_b) got = 1;
        end
        chk("restart_done", 64'(got), 64'd1);
        model_reset();
        rda = {5'd31, 5'd2}; rdb = {5'd31, 5'd2, 5'd1, 5'd31};
        check_reads("restart_zero");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised multi-read-port register file with a write-result scoreboard, optional write-to-read bypass and a sequenced clear engine. It replaces the fixed 32×32, two-read-port file in the pipelined RISC-V core. The decode stage reads operands and reserves destinations here, writeback writes results here, and the debug/boot logic clears it here.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width. Depth is `DEPTH = 2**ADDR_W`.
- `NUM_RD`, default 2: number of independent read ports, 1–4.
- `BYPASS`, default 1: when 1, a same-cycle write is forwarded to matching read ports.
- `ZERO_REG`, default 1: when 1, entry 0 reads as 0, is never written and is never busy.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `wr_ena` in 1: write strobe.
- `wr_addr` in `ADDR_W`: write address.
- `wr_data` in `DATA_W`: write data.
- `rsv_ena` in 1: reserve strobe; marks `rsv_addr` busy, meaning a result is pending.
- `rsv_addr` in `ADDR_W`: address to reserve.
- `rd_addr` in `NUM_RD*ADDR_W`: packed read addresses; port i uses bits `[i*ADDR_W +: ADDR_W]`.
- `rd_data` out `NUM_RD*DATA_W`: packed read data.
- `rd_busy` out `NUM_RD`: per-port flag; the addressed entry has an outstanding reservation.
- `clr_req` in 1: single-cycle pulse that starts a sequenced clear.
- `clr_busy` out 1: high while the clear engine runs.
- `clr_done` out 1: one-cycle pulse when the clear completes.

## Operation
- **Storage:** `DEPTH` entries of `DATA_W` bits, plus a `DEPTH`-bit busy vector.
- **Write:** `wr_ena` loads `wr_data` into `wr_addr` and clears `busy[wr_addr]`. When `ZERO_REG` is 1, writes to address 0 are dropped.
- **Reserve:** `rsv_ena` sets `busy[rsv_addr]`. When `ZERO_REG` is 1, reserves of address 0 are dropped.
- **Reserve and write to the same address in the same cycle:** the data is written and busy ends up 1, because the reservation belongs to a newer producer.
- **Reserve and write to different addresses:** both take effect.
- **Read data, port i:**
  - If `ZERO_REG` is 1 and the address is 0, the output is 0.
  - Otherwise, if `BYPASS` is 1, `wr_ena` is high and `wr_addr` equals the read address, the output is `wr_data`.
  - Otherwise the output is the stored entry.
- **Read busy, port i:** `busy[addr]`, except that it is forced to 0 when the bypass condition above hits.
- **Simultaneous reads:** all ports are independent; any number may address the same entry.
- **Clear FSM states:**
  - `RF_IDLE`: a `clr_req` pulse moves to `RF_CLEAR` with the clear pointer `clr_ptr` set to 0.
  - `RF_CLEAR`: each cycle writes 0 to entry `clr_ptr`, clears `busy[clr_ptr]`, then increments `clr_ptr`.
  - When `clr_ptr` reaches `DEPTH-1`, that entry is cleared, `clr_done` pulses in the following cycle, and the state returns to `RF_IDLE`.
- **While in `RF_CLEAR`:**
  - `wr_ena` and `rsv_ena` are ignored, so the upstream pipeline must stall on `clr_busy`.
  - Reads remain live and return the current, partially cleared contents, with bypass disabled.
  - Further `clr_req` pulses are ignored.
- **Pointer width:** `clr_ptr` is `ADDR_W` bits. Termination is detected by comparing against `DEPTH-1`, never by wrap to 0.

## Timing
- **Reset** (`rst` low, asynchronous):
  - all entries are 0 and the busy vector is 0;
  - the FSM is in `RF_IDLE`;
  - `clr_busy` and `clr_done` are 0;
  - `rd_data` is 0 and `rd_busy` is 0 for every port.
- **Reset mid-clear:** aborts the clear immediately; the state is as after reset.
- **Deassertion:** reset is sampled asynchronously; the first write takes effect on the first rising edge after deassertion.
- **Read latency:** 0 cycles (combinational from address and state).
- **Write and reserve latency:** visible in the stored state one cycle after the edge. With `BYPASS` set, a write is also visible on `rd_data` in the same cycle.
- **`clr_busy`:** rises the cycle after `clr_req` and stays high for exactly `DEPTH` cycles.
- **`clr_done`:** pulses in the cycle after `clr_busy` falls. Total clear is `DEPTH+1` cycles from the `clr_req` edge to `clr_done`.

## Structure
- **Shared package `register_file_pkg`:**
  - `rf_state_t` enum {`RF_IDLE`, `RF_CLEAR`};
  - RV32 constants `RV_DATA_W = 32` and `RV_ADDR_W = 5`, so instantiations in the core use the package values.
- **Sub-module `rf_wr_decoder`:** parametrised `ADDR_W`-to-`DEPTH` one-hot decoder with enable. It is shared by the write, reserve and clear paths, with three instances.
- **Top-level structure:** storage, busy vector, read muxes (a generate loop over `NUM_RD`) and the FSM all live in the top level.

## Test plan
- **Reset then read:** write `0xDEAD_BEEF` to x5, pulse `rst` low, read x5 on both ports. Required: `rd_data` is 0 and `rd_busy` is 0.
- **x0 protection:** write `0x1234` to x0 and reserve x0. Required: x0 reads 0 and x0 `rd_busy` stays 0.
- **Bypass:** `BYPASS` = 1; write `0xA5A5_0001` to x7 while port 1 reads x7. Required: same cycle `rd_data1` = `0xA5A5_0001` and `rd_busy[1]` = 0. With `BYPASS` = 0, the port reads the old value in that cycle and the new value the next cycle.
- **Scoreboard:**
  - reserve x3: `rd_busy` for x3 is 1 the next cycle;
  - reserve and write x3 in the same cycle: busy stays 1;
  - write x3 alone with value `0x42`: busy goes to 0 and data reads `0x42`.
- **Clear sequence:** fill all 31 entries with non-zero values, pulse `clr_req`, and drive `wr_ena` to x9 mid-clear. Required:
  - `clr_busy` is high for 32 cycles;
  - `clr_done` pulses once, in cycle 33;
  - every entry reads 0 afterwards;
  - the write to x9 is dropped.
- **Reset mid-clear and parametrisation:** assert `rst` at clear cycle 10. Required: `clr_busy` = 0 immediately, and a fresh `clr_req` restarts from entry 0. Separately, instantiate `NUM_RD` = 4 and `DATA_W` = 64; four ports reading four distinct entries must return independent correct values.
